// File: rtl/music_scheduler.sv
// Music scheduler: arbitrates between a looping background track and
// one-shot sound effects, producing ROM beat addresses and a registered
// tone for the audio driver. Effects pause the background track, which
// resumes where it stopped unless the game has left the menu meanwhile.
module music_scheduler #(
    parameter int          BGM_LEN = 512,
    parameter int          SFX_LEN = 16,
    parameter logic [31:0] SIL     = 32'd50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        beat_tick,
    input  logic [2:0]  state,
    input  logic        collision_trig,
    input  logic        mute,
    input  logic [31:0] bgm_tone,
    input  logic [31:0] sfx_tone,
    output logic [11:0] ibeat,
    output logic [5:0]  sfx_beat,
    output logic [31:0] tone_out,
    output logic        sfx_active,
    output logic        sfx_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BGM  = 2'd1,
        SFX  = 2'd2
    } fsm_t;

    localparam logic [11:0] BGM_LAST = 12'(BGM_LEN - 1);
    localparam logic [5:0]  SFX_LAST = 6'(SFX_LEN - 1);

    fsm_t        fsm;
    fsm_t        fsm_nxt;
    logic        trig_q;
    logic        trig_rise;
    logic [11:0] ibeat_nxt;
    logic [5:0]  sfx_beat_nxt;
    logic        done_nxt;

    // Tone arbitration uses the FSM state before the edge, so the
    // selected tone matches the addresses the ROMs were given.
    function automatic logic [31:0] tone_select(
        input fsm_t        cur,
        input logic        mute_i,
        input logic [31:0] bgm_i,
        input logic [31:0] sfx_i
    );
        logic [31:0] t;
        t = SIL;
        if (!mute_i) begin
            case (cur)
                BGM:     t = bgm_i;
                SFX:     t = sfx_i;
                default: t = SIL;
            endcase
        end
        return t;
    endfunction

    // Only a fresh low-to-high edge requests an effect; a held trigger
    // cannot restart the effect over and over.
    assign trig_rise = collision_trig & ~trig_q;

    // Next-state and address update logic; trigger edges win over beats.
    always_comb begin
        fsm_nxt      = fsm;
        ibeat_nxt    = ibeat;
        sfx_beat_nxt = sfx_beat;
        done_nxt     = 1'b0;
        case (fsm)
            IDLE: begin
                if (trig_rise) begin
                    fsm_nxt      = SFX;
                    sfx_beat_nxt = 6'd0;
                end else if (state == 3'd0) begin
                    fsm_nxt = BGM;
                end
            end
            BGM: begin
                if (trig_rise) begin
                    // Background position is kept so it can resume later.
                    fsm_nxt      = SFX;
                    sfx_beat_nxt = 6'd0;
                end else if (state != 3'd0) begin
                    fsm_nxt   = IDLE;
                    ibeat_nxt = 12'd0;
                end else if (beat_tick) begin
                    ibeat_nxt = (ibeat == BGM_LAST) ? 12'd0 : ibeat + 12'd1;
                end
            end
            SFX: begin
                if (trig_rise) begin
                    // Retrigger restarts the effect from its first beat.
                    sfx_beat_nxt = 6'd0;
                end else if (beat_tick) begin
                    if (sfx_beat < SFX_LAST) begin
                        sfx_beat_nxt = sfx_beat + 6'd1;
                    end else begin
                        // Game state is only consulted once the effect ends.
                        done_nxt     = 1'b1;
                        sfx_beat_nxt = 6'd0;
                        if (state == 3'd0) begin
                            fsm_nxt = BGM;
                        end else begin
                            fsm_nxt   = IDLE;
                            ibeat_nxt = 12'd0;
                        end
                    end
                end
            end
            default: begin
                fsm_nxt = IDLE;
            end
        endcase
    end

    // State, address, trigger history and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm        <= IDLE;
            ibeat      <= 12'd0;
            sfx_beat   <= 6'd0;
            trig_q     <= 1'b0;
            tone_out   <= SIL;
            sfx_active <= 1'b0;
            sfx_done   <= 1'b0;
        end else begin
            fsm        <= fsm_nxt;
            ibeat      <= ibeat_nxt;
            sfx_beat   <= sfx_beat_nxt;
            trig_q     <= collision_trig;
            tone_out   <= tone_select(fsm, mute, bgm_tone, sfx_tone);
            sfx_active <= (fsm_nxt == SFX);
            sfx_done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_music_scheduler.sv
// Directed bench for music_scheduler. Two instances share stimulus:
// A (BGM_LEN=4, SFX_LEN=8) covers wrap and reset mid-effect, B
// (BGM_LEN=16, SFX_LEN=4) covers pause/resume, retrigger, exit, held
// trigger and mute. ROM contents are modelled as tag | address.
module tb_music_scheduler;

    localparam logic [31:0] SIL = 32'd50000000;

    logic        clk = 1'b0;
    logic        rst;
    logic        beat_tick;
    logic [2:0]  state;
    logic        collision_trig;
    logic        mute;

    logic [31:0] bgm_tone_a, sfx_tone_a, tone_out_a;
    logic [11:0] ibeat_a;
    logic [5:0]  sfx_beat_a;
    logic        sfx_active_a, sfx_done_a;

    logic [31:0] bgm_tone_b, sfx_tone_b, tone_out_b;
    logic [11:0] ibeat_b;
    logic [5:0]  sfx_beat_b;
    logic        sfx_active_b, sfx_done_b;

    int checks = 0;
    int errors = 0;
    int done_cnt;

    always #5 clk = ~clk;

    assign bgm_tone_a = 32'hA000_0000 | 32'(ibeat_a);
    assign sfx_tone_a = 32'hA500_0000 | 32'(sfx_beat_a);
    assign bgm_tone_b = 32'hB000_0000 | 32'(ibeat_b);
    assign sfx_tone_b = 32'hB500_0000 | 32'(sfx_beat_b);

    music_scheduler #(.BGM_LEN(4), .SFX_LEN(8), .SIL(SIL)) dut_a (
        .clk(clk), .rst(rst), .beat_tick(beat_tick), .state(state),
        .collision_trig(collision_trig), .mute(mute),
        .bgm_tone(bgm_tone_a), .sfx_tone(sfx_tone_a),
        .ibeat(ibeat_a), .sfx_beat(sfx_beat_a), .tone_out(tone_out_a),
        .sfx_active(sfx_active_a), .sfx_done(sfx_done_a)
    );

    music_scheduler #(.BGM_LEN(16), .SFX_LEN(4), .SIL(SIL)) dut_b (
        .clk(clk), .rst(rst), .beat_tick(beat_tick), .state(state),
        .collision_trig(collision_trig), .mute(mute),
        .bgm_tone(bgm_tone_b), .sfx_tone(sfx_tone_b),
        .ibeat(ibeat_b), .sfx_beat(sfx_beat_b), .tone_out(tone_out_b),
        .sfx_active(sfx_active_b), .sfx_done(sfx_done_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_ib[5]   = '{1, 2, 3, 0, 1};
        int exp_prev[5] = '{0, 1, 2, 3, 0};
        int exp_sb[4]   = '{1, 2, 3, 0};
        int exp_dn[4]   = '{0, 0, 0, 1};

        rst = 1'b1; beat_tick = 1'b0; state = 3'd0;
        collision_trig = 1'b0; mute = 1'b0;
        tick(); tick();

        // Reset state
        check("rst_ibeat_b", ibeat_b, 0);
        check("rst_sfx_beat_b", sfx_beat_b, 0);
        check("rst_tone_b", tone_out_b, SIL);
        check("rst_active_b", sfx_active_b, 0);
        check("rst_done_b", sfx_done_b, 0);
        check("rst_ibeat_a", ibeat_a, 0);

        // Leave reset: IDLE -> BGM, tone still silent from IDLE
        rst = 1'b0;
        tick();
        check("post_rst_tone_b", tone_out_b, SIL);
        check("post_rst_active_b", sfx_active_b, 0);
        tick();
        check("bgm_entered_tone_a", tone_out_a, 32'hA000_0000);

        // Wrap with BGM_LEN=4 on instance A
        beat_tick = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("wrap_ibeat_%0d", i), ibeat_a, 32'(exp_ib[i]));
            check($sformatf("wrap_tone_%0d", i), tone_out_a, 32'hA000_0000 | 32'(exp_prev[i]));
        end
        beat_tick = 1'b0;
        tick();
        check("wrap_hold_ibeat", ibeat_a, 1);
        check("wrap_tone_late", tone_out_a, 32'hA000_0001);

        // Bring B to ibeat 7
        beat_tick = 1'b1;
        tick(); tick();
        beat_tick = 1'b0;
        check("b_at_7", ibeat_b, 7);

        // Pause/resume on B
        collision_trig = 1'b1;
        tick();
        collision_trig = 1'b0;
        check("pause_active", sfx_active_b, 1);
        check("pause_ibeat", ibeat_b, 7);
        check("pause_sfx_beat", sfx_beat_b, 0);
        check("pause_tone_bgm", tone_out_b, 32'hB000_0007);
        tick();
        check("pause_no_adv", sfx_beat_b, 0);
        check("pause_tone_sfx", tone_out_b, 32'hB500_0000);
        beat_tick = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("sfx_beat_%0d", i), sfx_beat_b, 32'(exp_sb[i]));
            check($sformatf("sfx_done_%0d", i), sfx_done_b, 32'(exp_dn[i]));
        end
        beat_tick = 1'b0;
        check("resume_active", sfx_active_b, 0);
        check("resume_ibeat", ibeat_b, 7);
        check("resume_tone_last_sfx", tone_out_b, 32'hB500_0003);
        tick();
        check("done_one_cycle", sfx_done_b, 0);
        check("resume_tone_bgm", tone_out_b, 32'hB000_0007);
        check("resume_ibeat_held", ibeat_b, 7);

        // Instance A is mid-effect at sfx_beat 4; one beat more -> 5
        beat_tick = 1'b1;
        tick();
        beat_tick = 1'b0;
        check("a_sfx_beat_5", sfx_beat_a, 5);
        check("a_active", sfx_active_a, 1);

        // Reset mid-effect with coincident trigger edge
        rst = 1'b1; collision_trig = 1'b1;
        tick();
        check("rstmid_ibeat", ibeat_a, 0);
        check("rstmid_sfx_beat", sfx_beat_a, 0);
        check("rstmid_tone", tone_out_a, SIL);
        check("rstmid_active", sfx_active_a, 0);
        check("rstmid_done", sfx_done_a, 0);
        rst = 1'b0; collision_trig = 1'b0;
        tick();

        // B now in BGM at 0; advance to 3
        beat_tick = 1'b1;
        tick(); tick(); tick();
        beat_tick = 1'b0;
        check("b_at_3", ibeat_b, 3);

        // Retrigger on B
        collision_trig = 1'b1;
        tick();
        collision_trig = 1'b0;
        beat_tick = 1'b1;
        tick(); tick();
        check("retrig_pre", sfx_beat_b, 2);
        collision_trig = 1'b1;
        tick();
        collision_trig = 1'b0; beat_tick = 1'b0;
        check("retrig_sfx_beat", sfx_beat_b, 0);
        check("retrig_active", sfx_active_b, 1);
        check("retrig_no_done", sfx_done_b, 0);
        check("retrig_ibeat_held", ibeat_b, 3);

        // Exit to game during effect
        state = 3'd3;
        beat_tick = 1'b1;
        tick(); tick(); tick();
        check("exit_not_aborted", sfx_active_b, 1);
        check("exit_sfx_beat3", sfx_beat_b, 3);
        tick();
        beat_tick = 1'b0;
        check("exit_done", sfx_done_b, 1);
        check("exit_active", sfx_active_b, 0);
        check("exit_ibeat", ibeat_b, 0);
        tick();
        check("exit_tone_sil", tone_out_b, SIL);
        tick();
        check("idle_stays", ibeat_b, 0);

        // Held trigger: exactly one effect
        state = 3'd0;
        tick();
        collision_trig = 1'b1; beat_tick = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sfx_done_b) done_cnt++;
        end
        collision_trig = 1'b0; beat_tick = 1'b0;
        check("held_one_effect", done_cnt, 1);
        check("held_active_low", sfx_active_b, 0);
        check("held_ibeat", ibeat_b, 15);
        tick();
        check("held_release_no_sfx", sfx_active_b, 0);
        check("pre_mute_tone", tone_out_b, 32'hB000_000F);

        // Mute in BGM
        mute = 1'b1; beat_tick = 1'b1;
        tick();
        check("mute_tone", tone_out_b, SIL);
        check("mute_ibeat_wrap", ibeat_b, 0);
        tick();
        check("mute_tone2", tone_out_b, SIL);
        check("mute_ibeat_adv", ibeat_b, 1);
        mute = 1'b0; beat_tick = 1'b0;
        tick();
        check("unmute_tone", tone_out_b, 32'hB000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
